// File: rtl/axi_byte_mem_slave_if.sv
// axi_byte_mem_slave_if
//   Bundles the five AXI-style channels that connect one master to
//   axi_byte_mem_slave. The bus is 8 bits wide and carries single-beat
//   transfers only.
//
//   Read address : s_axi_araddr[31:0], s_axi_arsize[2:0], s_axi_arvalid, s_axi_arready
//   Read data    : s_axi_rdata[7:0], s_axi_rresp[1:0], s_axi_rvalid, s_axi_rready
//   Write address: s_axi_awaddr[31:0], s_axi_awsize[2:0], s_axi_awvalid, s_axi_awready
//   Write data   : s_axi_wdata[7:0], s_axi_wstrb, s_axi_wvalid, s_axi_wready
//   Write resp   : s_axi_bresp[1:0], s_axi_bvalid, s_axi_bready
//
//   modport slave  - the memory side
//   modport master - the requesting side
interface axi_byte_mem_slave_if;
  logic [31:0] s_axi_araddr;
  logic [2:0]  s_axi_arsize;
  logic        s_axi_arvalid;
  logic        s_axi_arready;

  logic [7:0]  s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;

  logic [31:0] s_axi_awaddr;
  logic [2:0]  s_axi_awsize;
  logic        s_axi_awvalid;
  logic        s_axi_awready;

  logic [7:0]  s_axi_wdata;
  logic        s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;

  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;

  modport slave (
    input  s_axi_araddr, s_axi_arsize, s_axi_arvalid, s_axi_rready,
    input  s_axi_awaddr, s_axi_awsize, s_axi_awvalid,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid
  );

  modport master (
    output s_axi_araddr, s_axi_arsize, s_axi_arvalid, s_axi_rready,
    output s_axi_awaddr, s_axi_awsize, s_axi_awvalid,
    output s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid
  );
endinterface

// File: rtl/axi_byte_mem_slave.sv
// axi_byte_mem_slave
//   Byte-wide memory of 2^ADDR_W locations behind an AXI-style slave port.
//   Reads and writes run in two independent FSMs, each with at most one
//   transaction outstanding. Reads return data READ_LATENCY cycles after
//   the AR handshake. Accesses with any address bit at or above ADDR_W set,
//   or with a size other than one byte, get SLVERR and never touch memory.
//
//   Parameters:
//     ADDR_W       - decoded address bits (memory depth 2^ADDR_W bytes)
//     READ_LATENCY - AR handshake edge to rvalid, 1..15 cycles
//   Ports:
//     clk       - single clock, rising edge
//     m_aresetn - asynchronous active-low reset
//     s_axi     - slave modport of axi_byte_mem_slave_if (AR/R/AW/W/B)
module axi_byte_mem_slave #(
  parameter int ADDR_W       = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 m_aresetn,
  axi_byte_mem_slave_if.slave  s_axi
);

  localparam int         DEPTH       = 1 << ADDR_W;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rState_t;
  typedef enum logic       {W_IDLE, W_RESP}         wState_t;

  // Storage deliberately has no reset.
  logic [7:0]  r_mem [DEPTH];

  // Set on the first edge after reset release so the ready outputs only
  // come up once the clock has actually run.
  logic        r_live;

  rState_t     r_rState, w_rNext;
  logic [3:0]  r_rCnt, w_rCntNext;
  logic [31:0] r_arAddr;
  logic [2:0]  r_arSize;
  logic [7:0]  r_rdata;
  logic [1:0]  r_rresp;

  wState_t     r_wState, w_wNext;
  logic        r_awHeld, r_wHeld;
  logic [31:0] r_awAddr;
  logic [2:0]  r_awSize;
  logic [7:0]  r_wData;
  logic        r_wStrb;
  logic [1:0]  r_bresp;

  logic        w_arReady, w_rValid, w_awReady, w_wReady, w_bValid;
  logic        w_arHs, w_rHs, w_awHs, w_wHs, w_bHs;
  logic [31:0] w_rdAddr;
  logic [2:0]  w_rdSize;
  logic        w_rLoad;
  logic        w_commit, w_useHeld;
  logic [31:0] w_cAddr;
  logic [2:0]  w_cSize;
  logic [7:0]  w_cData;
  logic        w_cStrb;
  logic        w_cInRange;

  // Anything above the decoded bits is an error rather than an alias.
  function automatic logic inRange(input logic [31:0] addr, input logic [2:0] size);
    return ((addr >> ADDR_W) == 32'd0) && (size == 3'b000);
  endfunction

  assign w_arHs = s_axi.s_axi_arvalid && w_arReady;
  assign w_rHs  = w_rValid && s_axi.s_axi_rready;
  assign w_awHs = s_axi.s_axi_awvalid && w_awReady;
  assign w_wHs  = s_axi.s_axi_wvalid && w_wReady;
  assign w_bHs  = w_bValid && s_axi.s_axi_bready;

  // ---------------------------------------------------------------- read FSM
  // State register.
  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      r_live   <= 1'b0;
      r_rState <= R_IDLE;
      r_rCnt   <= 4'd0;
    end else begin
      r_live   <= 1'b1;
      r_rState <= w_rNext;
      r_rCnt   <= w_rCntNext;
    end
  end

  // Next state. The wait counter is loaded with READ_LATENCY-1 and the FSM
  // moves on once it has been seen at zero.
  always_comb begin
    w_rNext    = r_rState;
    w_rCntNext = r_rCnt;
    case (r_rState)
      R_IDLE: begin
        if (w_arHs) begin
          if (READ_LATENCY == 1) begin
            w_rNext = R_RESP;
          end else begin
            w_rNext    = R_WAIT;
            w_rCntNext = 4'(READ_LATENCY - 1);
          end
        end
      end
      R_WAIT: begin
        if (r_rCnt == 4'd0) begin
          w_rNext = R_RESP;
        end else begin
          w_rCntNext = r_rCnt - 4'd1;
        end
      end
      R_RESP: begin
        if (w_rHs) begin
          w_rNext = R_IDLE;
        end
      end
      default: w_rNext = R_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    w_arReady = r_live && (r_rState == R_IDLE);
    w_rValid  = (r_rState == R_RESP);
  end

  // With a latency of one the response is loaded straight from the live
  // request, so the address has to bypass the capture register.
  assign w_rdAddr = (r_rState == R_IDLE) ? s_axi.s_axi_araddr : r_arAddr;
  assign w_rdSize = (r_rState == R_IDLE) ? s_axi.s_axi_arsize : r_arSize;
  assign w_rLoad  = (w_rNext == R_RESP) && (r_rState != R_RESP);

  // Read datapath. Memory is sampled with a non-blocking read, so a write
  // committing on the same edge is not yet visible here.
  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      r_arAddr <= 32'd0;
      r_arSize <= 3'd0;
      r_rdata  <= 8'h00;
      r_rresp  <= RESP_OKAY;
    end else begin
      if (w_arHs) begin
        r_arAddr <= s_axi.s_axi_araddr;
        r_arSize <= s_axi.s_axi_arsize;
      end
      if (w_rLoad) begin
        if (inRange(w_rdAddr, w_rdSize)) begin
          r_rdata <= r_mem[w_rdAddr[ADDR_W-1:0]];
          r_rresp <= RESP_OKAY;
        end else begin
          r_rdata <= 8'h00;
          r_rresp <= RESP_SLVERR;
        end
      end
    end
  end

  // --------------------------------------------------------------- write FSM
  // A write commits either when both channels were already held, or when
  // both handshakes land in the same cycle. A handshake that completes the
  // pair in a later cycle therefore commits one edge after it.
  assign w_commit  = (r_wState == W_IDLE) &&
                     ((r_awHeld && r_wHeld) || (w_awHs && w_wHs));
  assign w_useHeld = r_awHeld && r_wHeld;
  assign w_cAddr   = w_useHeld ? r_awAddr : s_axi.s_axi_awaddr;
  assign w_cSize   = w_useHeld ? r_awSize : s_axi.s_axi_awsize;
  assign w_cData   = w_useHeld ? r_wData  : s_axi.s_axi_wdata;
  assign w_cStrb   = w_useHeld ? r_wStrb  : s_axi.s_axi_wstrb;
  assign w_cInRange = inRange(w_cAddr, w_cSize);

  // State register, holding flags and captured channel contents.
  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      r_wState <= W_IDLE;
      r_awHeld <= 1'b0;
      r_wHeld  <= 1'b0;
      r_awAddr <= 32'd0;
      r_awSize <= 3'd0;
      r_wData  <= 8'h00;
      r_wStrb  <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else begin
      r_wState <= w_wNext;
      if (w_bHs) begin
        r_awHeld <= 1'b0;
        r_wHeld  <= 1'b0;
      end else begin
        if (w_awHs) begin
          r_awHeld <= 1'b1;
          r_awAddr <= s_axi.s_axi_awaddr;
          r_awSize <= s_axi.s_axi_awsize;
        end
        if (w_wHs) begin
          r_wHeld <= 1'b1;
          r_wData <= s_axi.s_axi_wdata;
          r_wStrb <= s_axi.s_axi_wstrb;
        end
      end
      if (w_commit) begin
        r_bresp <= w_cInRange ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Next state.
  always_comb begin
    w_wNext = r_wState;
    case (r_wState)
      W_IDLE:  if (w_commit) w_wNext = W_RESP;
      W_RESP:  if (w_bHs)    w_wNext = W_IDLE;
      default: w_wNext = W_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    w_awReady = r_live && (r_wState == W_IDLE) && !r_awHeld;
    w_wReady  = r_live && (r_wState == W_IDLE) && !r_wHeld;
    w_bValid  = (r_wState == W_RESP);
  end

  // Storage update; a cleared strobe still gets an OKAY response.
  always_ff @(posedge clk) begin
    if (w_commit && w_cInRange && w_cStrb) begin
      r_mem[w_cAddr[ADDR_W-1:0]] <= w_cData;
    end
  end

  assign s_axi.s_axi_arready = w_arReady;
  assign s_axi.s_axi_rvalid  = w_rValid;
  assign s_axi.s_axi_rdata   = r_rdata;
  assign s_axi.s_axi_rresp   = r_rresp;
  assign s_axi.s_axi_awready = w_awReady;
  assign s_axi.s_axi_wready  = w_wReady;
  assign s_axi.s_axi_bvalid  = w_bValid;
  assign s_axi.s_axi_bresp   = r_bresp;

endmodule

// File: tb/tb_axi_byte_mem_slave.sv
// tb_axi_byte_mem_slave
//   Self-checking bench for axi_byte_mem_slave. A plain byte array stands in
//   for the memory and is updated from the access rules (in range means
//   address below the depth and single-byte size; only strobed in-range
//   writes change it). Directed scenarios are followed by random traffic.
module tb_axi_byte_mem_slave;
  localparam int ADDR_W       = 8;
  localparam int READ_LATENCY = 2;
  localparam int DEPTH        = 1 << ADDR_W;

  logic clk = 1'b0;
  logic m_aresetn;

  axi_byte_mem_slave_if bus ();

  axi_byte_mem_slave #(
    .ADDR_W       (ADDR_W),
    .READ_LATENCY (READ_LATENCY)
  ) dut (
    .clk       (clk),
    .m_aresetn (m_aresetn),
    .s_axi     (bus.slave)
  );

  always #5 clk = ~clk;

  int vecCnt  = 0;
  int missCnt = 0;

  logic [7:0] modelMem [DEPTH];

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit modelInRange(input logic [31:0] addr, input logic [2:0] size);
    return (addr < 32'(DEPTH)) && (size == 3'd0);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCnt++;
    assert (obs === exp) else begin
      missCnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // order: 0 = AW and W together, 1 = AW first, 2 = W first; gap = edges
  // between the two handshakes when they are split.
  task automatic writeTxn(input logic [31:0] addr, input logic [2:0] size, input logic [7:0] data,
                          input logic strb, input int order, input int gap, input int holdB);
    bit awLeft, wLeft, hsAw, hsW;
    int guard, gapCnt, lat;
    logic [1:0] expResp;
    expResp = modelInRange(addr, size) ? 2'b00 : 2'b10;
    bus.s_axi_awaddr  = addr;
    bus.s_axi_awsize  = size;
    bus.s_axi_wdata   = data;
    bus.s_axi_wstrb   = strb;
    bus.s_axi_awvalid = (order != 2);
    bus.s_axi_wvalid  = (order != 1);
    awLeft = 1; wLeft = 1; gapCnt = 0; guard = 0;
    while ((awLeft || wLeft) && guard < 40) begin
      hsAw = bus.s_axi_awvalid && bus.s_axi_awready;
      hsW  = bus.s_axi_wvalid && bus.s_axi_wready;
      step();
      guard++;
      if (hsAw) begin bus.s_axi_awvalid = 1'b0; awLeft = 0; end
      if (hsW)  begin bus.s_axi_wvalid  = 1'b0; wLeft  = 0; end
      if (order == 1 && !awLeft && wLeft) begin
        if (hsAw) gapCnt = 0; else gapCnt++;
        if (gapCnt >= gap - 1) bus.s_axi_wvalid = 1'b1;
      end
      if (order == 2 && !wLeft && awLeft) begin
        if (hsW) gapCnt = 0; else gapCnt++;
        if (gapCnt >= gap - 1) bus.s_axi_awvalid = 1'b1;
      end
    end
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wvalid  = 1'b0;
    checkOutput("wr handshakes done", {awLeft, wLeft}, 0);
    lat = 0;
    while (!bus.s_axi_bvalid && lat < 20) begin step(); lat++; end
    checkOutput("bvalid latency", lat, (order == 0) ? 0 : 1);
    repeat (holdB) step();
    checkOutput("bvalid/bresp", {bus.s_axi_bvalid, bus.s_axi_bresp}, {1'b1, expResp});
    bus.s_axi_bready = 1'b1;
    step();
    bus.s_axi_bready = 1'b0;
    checkOutput("after B handshake", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_bvalid}, 3'b110);
    if (modelInRange(addr, size) && strb) modelMem[addr[ADDR_W-1:0]] = data;
  endtask

  task automatic readTxn(input logic [31:0] addr, input logic [2:0] size, input int holdR);
    bit done, hs;
    int guard, lat;
    logic [7:0] expData;
    logic [1:0] expResp;
    expData = modelInRange(addr, size) ? modelMem[addr[ADDR_W-1:0]] : 8'h00;
    expResp = modelInRange(addr, size) ? 2'b00 : 2'b10;
    bus.s_axi_araddr  = addr;
    bus.s_axi_arsize  = size;
    bus.s_axi_arvalid = 1'b1;
    done = 0; guard = 0;
    while (!done && guard < 20) begin
      hs = bus.s_axi_arvalid && bus.s_axi_arready;
      step();
      guard++;
      if (hs) begin bus.s_axi_arvalid = 1'b0; done = 1; end
    end
    bus.s_axi_arvalid = 1'b0;
    checkOutput("ar handshake done", done, 1);
    lat = 0;
    while (!bus.s_axi_rvalid && lat < 40) begin step(); lat++; end
    checkOutput("rvalid latency", lat, READ_LATENCY);
    checkOutput("rdata/rresp", {bus.s_axi_rresp, bus.s_axi_rdata}, {expResp, expData});
    for (int i = 0; i < holdR; i++) begin
      step();
      checkOutput("R held stable", {bus.s_axi_rvalid, bus.s_axi_arready, bus.s_axi_rresp, bus.s_axi_rdata},
                  {1'b1, 1'b0, expResp, expData});
    end
    bus.s_axi_rready = 1'b1;
    step();
    bus.s_axi_rready = 1'b0;
    checkOutput("after R handshake", {bus.s_axi_rvalid, bus.s_axi_arready}, 2'b01);
  endtask

  // One random transaction, mostly in range with some address/size errors.
  task automatic applyStimulus();
    logic [31:0] addr;
    logic [2:0]  size;
    int sel;
    sel  = int'($urandom_range(0, 9));
    addr = 32'($urandom_range(0, DEPTH - 1));
    size = 3'd0;
    if (sel == 7) addr = addr | (32'h1 << $urandom_range(ADDR_W, 31));
    if (sel == 8) size = 3'($urandom_range(1, 7));
    if ($urandom_range(0, 1) == 0)
      writeTxn(addr, size, 8'($urandom), ($urandom_range(0, 3) != 0),
               int'($urandom_range(0, 2)), int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
    else
      readTxn(addr, size, int'($urandom_range(0, 3)));
  endtask

  initial begin
    int lat;
    m_aresetn         = 1'b0;
    bus.s_axi_araddr  = '0; bus.s_axi_arsize = '0; bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready  = 1'b0;
    bus.s_axi_awaddr  = '0; bus.s_axi_awsize = '0; bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata   = '0; bus.s_axi_wstrb  = 1'b0; bus.s_axi_wvalid = 1'b0;
    bus.s_axi_bready  = 1'b0;

    // Reset state and ready timing after release.
    repeat (3) step();
    checkOutput("reset outputs",
                {bus.s_axi_arready, bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_rvalid,
                 bus.s_axi_bvalid, bus.s_axi_rdata, bus.s_axi_rresp, bus.s_axi_bresp}, 0);
    m_aresetn = 1'b1;
    #2;
    checkOutput("ready before first edge", {bus.s_axi_arready, bus.s_axi_awready, bus.s_axi_wready}, 3'b000);
    step();
    checkOutput("ready after first edge", {bus.s_axi_arready, bus.s_axi_awready, bus.s_axi_wready}, 3'b111);

    // Fill the whole memory so every later read has a known value.
    for (int a = 0; a < DEPTH; a++)
      writeTxn(32'(a), 3'd0, 8'($urandom), 1'b1, a % 3, 1 + (a % 3), 0);

    // AW then W three cycles later, then read back.
    writeTxn(32'h10, 3'd0, 8'h5A, 1'b1, 1, 3, 0);
    readTxn(32'h10, 3'd0, 0);

    // Out-of-range read and write, no aliasing onto location 0.
    readTxn(32'h100, 3'd0, 0);
    writeTxn(32'h100, 3'd0, 8'hE7, 1'b1, 0, 1, 0);
    readTxn(32'h0, 3'd0, 0);
    writeTxn(32'h12, 3'b001, 8'h3C, 1'b1, 0, 1, 0);
    readTxn(32'h12, 3'b010, 0);
    readTxn(32'h12, 3'd0, 0);

    // Slow R consumer.
    readTxn(32'h10, 3'd0, 5);

    // Cleared strobe, W first and simultaneous.
    writeTxn(32'h44, 3'd0, 8'hFF, 1'b0, 2, 2, 1);
    readTxn(32'h44, 3'd0, 0);
    writeTxn(32'h45, 3'd0, 8'hFF, 1'b0, 0, 1, 0);
    readTxn(32'h45, 3'd0, 0);

    // Read sampling and write commit on the same edge.
    writeTxn(32'h20, 3'd0, 8'h11, 1'b1, 0, 1, 0);
    bus.s_axi_araddr = 32'h20; bus.s_axi_arsize = 3'd0; bus.s_axi_arvalid = 1'b1;
    step();
    bus.s_axi_arvalid = 1'b0;
    repeat (READ_LATENCY - 1) step();
    bus.s_axi_awaddr = 32'h20; bus.s_axi_awsize = 3'd0;
    bus.s_axi_wdata  = 8'h22;  bus.s_axi_wstrb  = 1'b1;
    bus.s_axi_awvalid = 1'b1;  bus.s_axi_wvalid = 1'b1;
    step();
    bus.s_axi_awvalid = 1'b0;  bus.s_axi_wvalid = 1'b0;
    checkOutput("collision read old", {bus.s_axi_rvalid, bus.s_axi_rresp, bus.s_axi_rdata}, {1'b1, 2'b00, 8'h11});
    checkOutput("collision write resp", {bus.s_axi_bvalid, bus.s_axi_bresp}, {1'b1, 2'b00});
    bus.s_axi_rready = 1'b1; bus.s_axi_bready = 1'b1;
    step();
    bus.s_axi_rready = 1'b0; bus.s_axi_bready = 1'b0;
    modelMem[8'h20] = 8'h22;
    readTxn(32'h20, 3'd0, 0);

    // Reset with AW held and a read waiting.
    bus.s_axi_awaddr = 32'h30; bus.s_axi_awsize = 3'd0; bus.s_axi_awvalid = 1'b1;
    step();
    bus.s_axi_awvalid = 1'b0;
    checkOutput("aw held", {bus.s_axi_awready, bus.s_axi_wready}, 2'b01);
    bus.s_axi_araddr = 32'h40; bus.s_axi_arsize = 3'd0; bus.s_axi_arvalid = 1'b1;
    step();
    bus.s_axi_arvalid = 1'b0;
    checkOutput("read waiting", {bus.s_axi_rvalid, bus.s_axi_arready}, 2'b00);
    m_aresetn = 1'b0;
    #1;
    checkOutput("mid-txn reset outputs",
                {bus.s_axi_arready, bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_rvalid,
                 bus.s_axi_bvalid, bus.s_axi_rdata, bus.s_axi_rresp, bus.s_axi_bresp}, 0);
    repeat (2) step();
    m_aresetn = 1'b1;
    #2;
    checkOutput("ready before release edge", {bus.s_axi_arready, bus.s_axi_awready, bus.s_axi_wready}, 3'b000);
    step();
    checkOutput("ready after release edge", {bus.s_axi_arready, bus.s_axi_awready, bus.s_axi_wready}, 3'b111);
    for (int i = 0; i < 6; i++) begin
      step();
      checkOutput("no stale response", {bus.s_axi_rvalid, bus.s_axi_bvalid}, 2'b00);
    end
    // A lone W must not pair with the AW lost in reset.
    bus.s_axi_wdata = 8'hC3; bus.s_axi_wstrb = 1'b1; bus.s_axi_wvalid = 1'b1;
    step();
    bus.s_axi_wvalid = 1'b0;
    repeat (2) step();
    checkOutput("lone W no response", {bus.s_axi_bvalid, bus.s_axi_awready, bus.s_axi_wready}, 3'b010);
    bus.s_axi_awaddr = 32'h30; bus.s_axi_awsize = 3'd0; bus.s_axi_awvalid = 1'b1;
    step();
    bus.s_axi_awvalid = 1'b0;
    lat = 0;
    while (!bus.s_axi_bvalid && lat < 20) begin step(); lat++; end
    checkOutput("late AW bvalid latency", lat, 1);
    checkOutput("late AW bresp", bus.s_axi_bresp, 2'b00);
    bus.s_axi_bready = 1'b1;
    step();
    bus.s_axi_bready = 1'b0;
    modelMem[8'h30] = 8'hC3;
    readTxn(32'h30, 3'd0, 0);
    readTxn(32'h40, 3'd0, 0);

    // Random traffic against the model.
    for (int n = 0; n < 80; n++) applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

endmodule

// File: doc/axi_byte_mem_slave.md
AXI_BYTE_MEM_SLAVE -- requirements
Module: axi_byte_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, giving the number of decoded address bits (memory depth 2^ADDR_W bytes).
REQ-002 SHALL have parameter READ_LATENCY, default 2, legal range 1..15, giving cycles from AR handshake edge to rvalid assertion.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port m_aresetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports s_axi_araddr in 32, s_axi_arsize in 3, s_axi_arvalid in 1, s_axi_arready out 1: read address channel.
REQ-006 SHALL have ports s_axi_rdata out 8, s_axi_rresp out 2, s_axi_rvalid out 1, s_axi_rready in 1: read data channel.
REQ-007 SHALL have ports s_axi_awaddr in 32, s_axi_awsize in 3, s_axi_awvalid in 1, s_axi_awready out 1: write address channel.
REQ-008 SHALL have ports s_axi_wdata in 8, s_axi_wstrb in 1, s_axi_wvalid in 1, s_axi_wready out 1: write data channel.
REQ-009 SHALL have ports s_axi_bresp out 2, s_axi_bvalid out 1, s_axi_bready in 1: write response channel.

Function
REQ-010 SHALL implement 2^ADDR_W x 8-bit storage; contents not reset.
REQ-011 SHALL treat an address as in-range only when addr[31:ADDR_W]==0 and size==3'b000; otherwise the response is SLVERR (2'b10).
REQ-012 SHALL run an independent read FSM with states R_IDLE, R_WAIT, R_RESP.
REQ-013 SHALL drive arready=1 only in R_IDLE; the AR handshake (arvalid&&arready) captures araddr/arsize and leaves R_IDLE.
REQ-014 SHALL go R_IDLE->R_RESP when READ_LATENCY==1, else to R_WAIT with down-counter READ_LATENCY-1, moving to R_RESP on count zero; rvalid rises exactly READ_LATENCY cycles after the handshake edge.
REQ-015 SHALL, on entering R_RESP, register rdata=mem[addr] and rresp=OKAY (2'b00) if in-range, else rdata=8'h00 and rresp=SLVERR.
REQ-016 SHALL hold rvalid, rdata, rresp stable until rready; on rvalid&&rready return to R_IDLE (arready=1 next cycle, one transaction outstanding max).
REQ-017 SHALL run an independent write FSM with states W_IDLE, W_RESP, with per-channel holding flags aw_held, w_held.
REQ-018 SHALL in W_IDLE drive awready=!aw_held and wready=!w_held; AW and W are accepted in either order or the same cycle, each captured on its handshake.
REQ-019 SHALL, in the cycle both flags are set (or both handshakes coincide), commit the write on the next edge and enter W_RESP with bvalid=1.
REQ-020 SHALL update memory only when in-range and wstrb==1; wstrb==0 in-range gives bresp=OKAY with no update; out-of-range gives bresp=SLVERR and no update.
REQ-021 SHALL hold bvalid/bresp until bready, then clear both flags and return to W_IDLE.
REQ-022 SHALL, when a read samples memory on the same edge a write commits to the same address, return the pre-write data.
REQ-023 SHALL ignore address bits above ADDR_W for indexing; no wrap-around aliasing (out-of-range is error, not wrapped).

Reset
REQ-024 SHALL, while m_aresetn==0, force arready, awready, wready, rvalid, bvalid to 0, rdata=8'h00, rresp=bresp=2'b00, both FSMs to idle, flags and counter cleared.
REQ-025 SHALL, on reset assertion mid-transaction, drop the pending transaction (uncommitted write lost, no response issued).
REQ-026 SHALL assert arready, awready, wready on the first rising edge after reset deassertion.

Verification
REQ-027 SHALL cover write 0x5A to 0x00000010 (AW then W 3 cycles later) -> bvalid one cycle after W handshake, bresp=00; subsequent read returns 0x5A, rresp=00, rvalid 2 cycles after AR handshake.
REQ-028 SHALL cover read from 0x00000100 (ADDR_W=8) -> rdata=0x00, rresp=10; write to same -> bresp=10, memory unchanged.
REQ-029 SHALL cover rready held low 5 cycles -> rvalid/rdata stable 5 cycles, arready stays 0 until handshake completes.
REQ-030 SHALL cover W before AW and simultaneous AW+W with wstrb=0 -> bresp=00, memory location unchanged.
REQ-031 SHALL cover read and write to 0x20 (old 0x11, new 0x22) committing on the same edge -> read returns 0x11, later read 0x22.
REQ-032 SHALL cover reset asserted in R_WAIT and with aw_held=1 -> all valids 0, no response after release, awready=1 first edge after release.
